// File: rtl/box_pkg.sv
// box_pkg: shared types and helpers for the box_regfile register file.
//   box_state_e : sequencer states (IDLE = normal access, CLEAR = array sweep)
//   box_merge   : per-bit masked merge used by the write port and the bypass path
// No ports (package).
package box_pkg;

  typedef enum logic {
    BOX_IDLE  = 1'b0,
    BOX_CLEAR = 1'b1
  } box_state_e;

  // Widest entry the merge helper handles; callers zero-extend into it and
  // truncate the result back to DATA_W.
  localparam int BOX_MAX_W = 64;

  // Bits with mask = 1 take the new data, bits with mask = 0 keep the old value.
  function automatic logic [BOX_MAX_W-1:0] box_merge(
    input logic [BOX_MAX_W-1:0] old_val,
    input logic [BOX_MAX_W-1:0] new_val,
    input logic [BOX_MAX_W-1:0] mask
  );
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/box_regfile_if.sv
// box_regfile_if: access bus of the register file.
//   master : write port (wr_*), two read requests (rd_en_x/rd_addr_x), clr_req;
//            receives rd_data_x/rd_valid_x, busy, clr_done, err
//   slave  : the register file side of the same signals
// clk and rst are not part of the bus.
interface box_regfile_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] wr_mask;
  logic              rd_en_a;
  logic [ADDR_W-1:0] rd_addr_a;
  logic              rd_en_b;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              clr_req;
  logic [DATA_W-1:0] rd_data_a;
  logic              rd_valid_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_valid_b;
  logic              busy;
  logic              clr_done;
  logic              err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask,
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, clr_req,
    input  rd_data_a, rd_valid_a, rd_data_b, rd_valid_b,
    input  busy, clr_done, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask,
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, clr_req,
    output rd_data_a, rd_valid_a, rd_data_b, rd_valid_b,
    output busy, clr_done, err
  );
endinterface

// File: rtl/box_rd_port.sv
// box_rd_port: one registered read port of box_regfile.
//   clk, rst      : clock, synchronous active-high reset
//   rd_en_i       : read request, already suppressed by the parent during a clear
//   rd_addr_i     : read address
//   mem_flat_i    : current array contents, entry i at [i*DATA_W +: DATA_W]
//   wr_act_i      : a legal write is being committed this cycle
//   wr_addr_i     : its address
//   wr_data_i     : its post-merge value (bypass source)
//   rd_data_o     : registered read data (holds when no read)
//   rd_valid_o    : registered read valid
//   oor_o         : combinational, this cycle's read request is out of range
module box_rd_port #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_en_i,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  input  logic [DEPTH*DATA_W-1:0] mem_flat_i,
  input  logic                    wr_act_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  output logic [DATA_W-1:0]       rd_data_o,
  output logic                    rd_valid_o,
  output logic                    oor_o
);

  // Compare one bit wider than the address so a non-power-of-2 DEPTH is exact.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic              in_range_s;
  logic [DATA_W-1:0] entry_s;
  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_valid_d, rd_valid_q;

  assign in_range_s = ({1'b0, rd_addr_i} < DEPTH_X);
  assign oor_o      = rd_en_i & ~in_range_s;

  // Select the addressed entry from the flattened array.
  always_comb begin
    entry_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_i == ADDR_W'(i)) begin
        entry_s = mem_flat_i[i*DATA_W +: DATA_W];
      end else begin
        entry_s = entry_s;
      end
    end
  end

  // Next read result: out-of-range reads return zero, a same-address write is bypassed.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (rd_en_i) begin
      rd_valid_d = 1'b1;
      if (!in_range_s) begin
        rd_data_d = '0;
      end else if (wr_act_i && (wr_addr_i == rd_addr_i)) begin
        rd_data_d = wr_data_i;
      end else begin
        rd_data_d = entry_s;
      end
    end else begin
      rd_valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/box_regfile.sv
// box_regfile: DEPTH x DATA_W register file, one masked write port, two
// registered read ports with same-cycle write bypass, and a clear sequencer
// that zeroes one entry per cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : box_regfile_if.slave (write, read A/B, clr_req, status outputs)
module box_regfile
  import box_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input logic          clk,
  input logic          rst,
  box_regfile_if.slave bus
);

  localparam int              ADDR_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DATA_W-1:0]       mem_d [DEPTH];
  box_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       clr_cnt_q, clr_cnt_d;
  logic                    busy_q, busy_d;
  logic                    clr_done_q, clr_done_d;
  logic                    err_q, err_d;

  logic                    idle_s;
  logic                    wr_ok_s;
  logic                    wr_act_s;
  logic [DATA_W-1:0]       wr_old_s;
  logic [DATA_W-1:0]       wr_merged_s;
  logic [DEPTH*DATA_W-1:0] mem_flat_s;
  logic                    oor_a_s, oor_b_s;

  assign idle_s   = (state_q == BOX_IDLE);
  assign wr_ok_s  = ({1'b0, bus.wr_addr} < DEPTH_X);
  assign wr_act_s = idle_s & bus.wr_en & wr_ok_s;

  // Current value of the write target and the flattened array for the read ports.
  always_comb begin
    wr_old_s   = '0;
    mem_flat_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_flat_s[i*DATA_W +: DATA_W] = mem_q[i];
      if (bus.wr_addr == ADDR_W'(i)) begin
        wr_old_s = mem_q[i];
      end else begin
        wr_old_s = wr_old_s;
      end
    end
  end

  assign wr_merged_s = DATA_W'(box_merge(BOX_MAX_W'(wr_old_s), BOX_MAX_W'(bus.wr_data),
                                         BOX_MAX_W'(bus.wr_mask)));

  box_rd_port #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rd_a (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (bus.rd_en_a & idle_s),
    .rd_addr_i  (bus.rd_addr_a),
    .mem_flat_i (mem_flat_s),
    .wr_act_i   (wr_act_s),
    .wr_addr_i  (bus.wr_addr),
    .wr_data_i  (wr_merged_s),
    .rd_data_o  (bus.rd_data_a),
    .rd_valid_o (bus.rd_valid_a),
    .oor_o      (oor_a_s)
  );

  box_rd_port #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rd_b (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (bus.rd_en_b & idle_s),
    .rd_addr_i  (bus.rd_addr_b),
    .mem_flat_i (mem_flat_s),
    .wr_act_i   (wr_act_s),
    .wr_addr_i  (bus.wr_addr),
    .wr_data_i  (wr_merged_s),
    .rd_data_o  (bus.rd_data_b),
    .rd_valid_o (bus.rd_valid_b),
    .oor_o      (oor_b_s)
  );

  // Sequencer, array update and status pulses.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    busy_d     = busy_q;
    clr_done_d = 1'b0;
    err_d      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    case (state_q)
      BOX_IDLE: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_act_s && (bus.wr_addr == ADDR_W'(i))) begin
            mem_d[i] = wr_merged_s;
          end else begin
            mem_d[i] = mem_q[i];
          end
        end
        // All violations of one cycle fold into a single err pulse.
        err_d = (bus.wr_en & ~wr_ok_s) | oor_a_s | oor_b_s;
        // Accesses in the clr_req cycle are serviced; the sweep starts next cycle.
        if (bus.clr_req) begin
          state_d   = BOX_CLEAR;
          clr_cnt_d = '0;
          busy_d    = 1'b1;
        end else begin
          state_d   = BOX_IDLE;
          busy_d    = 1'b0;
        end
      end
      BOX_CLEAR: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (clr_cnt_q == ADDR_W'(i)) begin
            mem_d[i] = '0;
          end else begin
            mem_d[i] = mem_q[i];
          end
        end
        // Accesses are refused while sweeping; clr_req is ignored.
        err_d = bus.wr_en | bus.rd_en_a | bus.rd_en_b;
        if (clr_cnt_q == LAST) begin
          state_d    = BOX_IDLE;
          clr_cnt_d  = '0;
          busy_d     = 1'b0;
          clr_done_d = 1'b1;
        end else begin
          clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d   = BOX_IDLE;
        clr_cnt_d = '0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOX_IDLE;
      clr_cnt_q  <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
      err_q      <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.clr_done = clr_done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_box_regfile.sv
// Testbench for box_regfile: a DEPTH=4 and a DEPTH=5 instance driven by
// directed steps; a reference model pushes per-cycle expected outputs into a
// queue that is popped and compared after each rising edge.
module tb_box_regfile;

  typedef struct {
    int         d;
    logic       va;
    logic [7:0] da;
    logic       vb;
    logic [7:0] db;
    logic       err;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t       exp_q [$];
  logic [7:0] mdl   [2][8];
  int         bcnt  [2];
  logic [7:0] la    [2];
  logic [7:0] lb    [2];

  box_regfile_if #(.DATA_W(8), .DEPTH(4)) if4 ();
  box_regfile_if #(.DATA_W(8), .DEPTH(5)) if5 ();

  box_regfile #(.DATA_W(8), .DEPTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  box_regfile #(.DATA_W(8), .DEPTH(5)) u_dut5 (.clk(clk), .rst(rst), .bus(if5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL d%0d %s: got %h expected %h", d, tag, obs, exp);
    end
  endtask

  // Reference behaviour of one instance for one cycle of inputs.
  task automatic model(input int d, input logic r, input logic clr, input logic we, input int wa,
                       input logic [7:0] wd, input logic [7:0] wm, input logic ea, input int aa,
                       input logic eb, input int ab);
    int         dep;
    logic [7:0] nv;
    logic       wok;
    exp_t       e;
    dep = (d == 0) ? 4 : 5;
    e.d = d; e.va = 1'b0; e.da = 8'h00; e.vb = 1'b0; e.db = 8'h00;
    e.err = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    if (r) begin
      for (int i = 0; i < 8; i++) mdl[d][i] = 8'h00;
      bcnt[d] = 0; la[d] = 8'h00; lb[d] = 8'h00;
    end else if (bcnt[d] == 0) begin
      wok = we && (wa < dep);
      nv  = wok ? ((mdl[d][wa] & ~wm) | (wd & wm)) : 8'h00;
      if (ea) begin
        e.va = 1'b1;
        e.da = (aa >= dep) ? 8'h00 : ((wok && aa == wa) ? nv : mdl[d][aa]);
        la[d] = e.da;
      end else e.da = la[d];
      if (eb) begin
        e.vb = 1'b1;
        e.db = (ab >= dep) ? 8'h00 : ((wok && ab == wa) ? nv : mdl[d][ab]);
        lb[d] = e.db;
      end else e.db = lb[d];
      e.err = (we && wa >= dep) || (ea && aa >= dep) || (eb && ab >= dep);
      if (wok) mdl[d][wa] = nv;
      e.busy = clr;
      if (clr) bcnt[d] = dep;
    end else begin
      e.da = la[d]; e.db = lb[d];
      e.err = we | ea | eb;
      mdl[d][dep - bcnt[d]] = 8'h00;
      bcnt[d] = bcnt[d] - 1;
      e.busy = (bcnt[d] != 0);
      e.done = (bcnt[d] == 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    repeat (2) begin
      e = exp_q.pop_front();
      if (e.d == 0) begin
        chk("rd_valid_a", 0, {7'd0, if4.rd_valid_a}, {7'd0, e.va});
        chk("rd_data_a",  0, if4.rd_data_a, e.da);
        chk("rd_valid_b", 0, {7'd0, if4.rd_valid_b}, {7'd0, e.vb});
        chk("rd_data_b",  0, if4.rd_data_b, e.db);
        chk("err",        0, {7'd0, if4.err}, {7'd0, e.err});
        chk("busy",       0, {7'd0, if4.busy}, {7'd0, e.busy});
        chk("clr_done",   0, {7'd0, if4.clr_done}, {7'd0, e.done});
      end else begin
        chk("rd_valid_a", 1, {7'd0, if5.rd_valid_a}, {7'd0, e.va});
        chk("rd_data_a",  1, if5.rd_data_a, e.da);
        chk("rd_valid_b", 1, {7'd0, if5.rd_valid_b}, {7'd0, e.vb});
        chk("rd_data_b",  1, if5.rd_data_b, e.db);
        chk("err",        1, {7'd0, if5.err}, {7'd0, e.err});
        chk("busy",       1, {7'd0, if5.busy}, {7'd0, e.busy});
        chk("clr_done",   1, {7'd0, if5.clr_done}, {7'd0, e.done});
      end
    end
  endtask

  // Drive one cycle on instance d (the other instance sees idle inputs), model, check.
  task automatic cyc(input int d, input logic r, input logic clr, input logic we, input int wa,
                     input logic [7:0] wd, input logic [7:0] wm, input logic ea, input int aa,
                     input logic eb, input int ab);
    logic s4, s5;
    s4 = (d == 0); s5 = (d == 1);
    rst = r;
    if4.clr_req = s4 & clr; if4.wr_en = s4 & we; if4.wr_addr = 2'(wa);
    if4.wr_data = wd; if4.wr_mask = wm;
    if4.rd_en_a = s4 & ea; if4.rd_addr_a = 2'(aa); if4.rd_en_b = s4 & eb; if4.rd_addr_b = 2'(ab);
    if5.clr_req = s5 & clr; if5.wr_en = s5 & we; if5.wr_addr = 3'(wa);
    if5.wr_data = wd; if5.wr_mask = wm;
    if5.rd_en_a = s5 & ea; if5.rd_addr_a = 3'(aa); if5.rd_en_b = s5 & eb; if5.rd_addr_b = 3'(ab);
    model(0, r, s4 & clr, s4 & we, wa, wd, wm, s4 & ea, aa, s4 & eb, ab);
    model(1, r, s5 & clr, s5 & we, wa, wd, wm, s5 & ea, aa, s5 & eb, ab);
    tick();
  endtask

  task automatic wr(input int d, input int a, input logic [7:0] v, input logic [7:0] m);
    cyc(d, 1'b0, 1'b0, 1'b1, a, v, m, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic rd2(input int d, input logic ea, input int aa, input logic eb, input int ab);
    cyc(d, 1'b0, 1'b0, 1'b0, 0, 8'h00, 8'h00, ea, aa, eb, ab);
  endtask

  initial begin
    // Reset state of both instances.
    cyc(0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b0, 0, 1'b0, 0);
    cyc(0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b0, 0, 1'b0, 0);

    // Reads after reset return zero with latency 1.
    for (int a = 0; a < 4; a++) rd2(0, 1'b1, a, 1'b0, 0);
    rd2(0, 1'b0, 0, 1'b0, 0);

    // Masked writes, dual read of the same address, zero-mask no-op.
    wr(0, 2, 8'hA5, 8'hFF);
    wr(0, 2, 8'h3C, 8'h0F);
    rd2(0, 1'b1, 2, 1'b1, 2);
    wr(0, 2, 8'hFF, 8'h00);
    rd2(0, 1'b1, 2, 1'b0, 0);

    // Same-cycle write/read bypass on A, independent read on B.
    cyc(0, 1'b0, 1'b0, 1'b1, 1, 8'h77, 8'hFF, 1'b1, 1, 1'b1, 0);
    cyc(0, 1'b0, 1'b0, 1'b1, 3, 8'h5C, 8'hF0, 1'b1, 2, 1'b1, 3);

    // Fill, then clear; clr cycle also writes and bypass-reads addr 0.
    wr(0, 0, 8'h11, 8'hFF); wr(0, 1, 8'h22, 8'hFF);
    wr(0, 2, 8'h33, 8'hFF); wr(0, 3, 8'h44, 8'hFF);
    cyc(0, 1'b0, 1'b1, 1'b1, 0, 8'h99, 8'hFF, 1'b1, 0, 1'b1, 3);
    rd2(0, 1'b1, 0, 1'b1, 1);
    cyc(0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 8'h00, 1'b0, 0, 1'b0, 0);
    wr(0, 2, 8'hEE, 8'hFF);
    rd2(0, 1'b0, 0, 1'b0, 0);
    rd2(0, 1'b1, 0, 1'b1, 1);
    rd2(0, 1'b1, 2, 1'b1, 3);

    // DEPTH=5: out-of-range write and reads, boundary entry 4, 5-cycle clear.
    wr(1, 1, 8'h5A, 8'hFF);
    wr(1, 4, 8'hC3, 8'hFF);
    wr(1, 6, 8'hFF, 8'hFF);
    rd2(1, 1'b1, 7, 1'b1, 1);
    cyc(1, 1'b0, 1'b0, 1'b1, 5, 8'h12, 8'hFF, 1'b1, 6, 1'b1, 7);
    rd2(1, 1'b1, 0, 1'b1, 2);
    rd2(1, 1'b1, 3, 1'b1, 4);
    rd2(1, 1'b0, 0, 1'b0, 0);
    cyc(1, 1'b0, 1'b1, 1'b0, 0, 8'h00, 8'h00, 1'b0, 0, 1'b0, 0);
    for (int k = 0; k < 5; k++) rd2(1, 1'b0, 0, 1'b0, 0);
    rd2(1, 1'b1, 1, 1'b1, 4);

    // Reset in the second cycle of a clear aborts it without clr_done.
    wr(0, 1, 8'hAB, 8'hFF);
    wr(0, 3, 8'hCD, 8'hFF);
    cyc(0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 8'h00, 1'b0, 0, 1'b0, 0);
    rd2(0, 1'b0, 0, 1'b0, 0);
    cyc(0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b0, 0, 1'b0, 0);
    cyc(0, 1'b0, 1'b0, 1'b1, 1, 8'h42, 8'hFF, 1'b1, 1, 1'b1, 3);
    rd2(0, 1'b1, 1, 1'b1, 2);
    for (int k = 0; k < 4; k++) rd2(0, 1'b0, 0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/box_regfile.md
Name: box_regfile

Overview:
Parametrised successor to the 4x8 register box: a DEPTH x DATA_W register file with one masked write port and two independent registered read ports. Same-cycle writes are bypassed to both read ports. A hardware clear sequencer zeroes the array one entry per cycle. It sits behind the datapath control logic as a small scratch/state store and is driven directly by single-cycle enables (no backpressure).

Parameters:
DATA_W, 8, entry width in bits (>=1)
DEPTH, 4, number of entries (>=2, need not be a power of 2)
ADDR_W, $clog2(DEPTH), address width (derived; do not override)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_mask  in  DATA_W  per-bit write enable (1 = update bit)
rd_en_a  in  1  read request, port A
rd_addr_a  in  ADDR_W  read address, port A
rd_en_b  in  1  read request, port B
rd_addr_b  in  ADDR_W  read address, port B
clr_req  in  1  start array clear
rd_data_a  out  DATA_W  registered read data, port A
rd_valid_a  out  1  rd_data_a valid this cycle
rd_data_b  out  DATA_W  registered read data, port B
rd_valid_b  out  1  rd_data_b valid this cycle
busy  out  1  clear sequence in progress
clr_done  out  1  one-cycle pulse when clear finishes
err  out  1  one-cycle pulse on rejected access

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. Reset zeroes all entries, rd_data_a/b, rd_valid_a/b, busy, clr_done and err. FSM goes to IDLE and clr_cnt to 0. Reset overrides everything, including a clear in progress.
- Write (IDLE): if wr_en and wr_addr < DEPTH, then at the edge mem[wr_addr] <= (mem & ~wr_mask) | (wr_data & wr_mask). wr_mask = 0 is a legal no-op.
- Read (IDLE): latency 1. If rd_en_x and rd_addr_x < DEPTH, then the next cycle rd_data_x = entry value and rd_valid_x = 1. If rd_en_x = 0, then rd_valid_x = 0 and rd_data_x holds its previous value.
- Bypass: if a read and a legal write in the same cycle target the same address, the read returns the post-write merged value. Both ports bypass independently.
- Both ports may read the same address in the same cycle; each returns an identical value.
- Out of range (addr >= DEPTH, only possible when DEPTH is not a power of 2):
  - Write: dropped, err pulses next cycle.
  - Read: rd_valid_x = 1, rd_data_x = 0, err pulses next cycle.
  - Multiple violations in one cycle give a single err pulse.
- FSM states IDLE and CLEAR.
  - IDLE -> CLEAR when clr_req = 1. clr_cnt = 0 and busy = 1 from the next cycle.
  - In CLEAR: mem[clr_cnt] <= 0 each cycle, clr_cnt increments.
  - When clr_cnt = DEPTH-1: that entry is cleared, then return to IDLE with busy = 0 and clr_done = 1 for exactly one cycle.
  - Total busy time is DEPTH cycles.
- Access during CLEAR: wr_en is dropped. rd_en_x gives rd_valid_x = 0 and rd_data_x holds. Any such attempt pulses err the next cycle. clr_req during CLEAR is ignored (no restart).
- clr_req in the same IDLE cycle as wr_en/rd_en: the write and reads are serviced normally in that cycle, then the clear starts. The write is later zeroed by the sweep.
- Widths: clr_cnt is ADDR_W bits and never exceeds DEPTH-1. Address compares are done at ADDR_W+1 bits.

Decomposition:
- Package box_pkg:
  - state enum box_state_e {BOX_IDLE, BOX_CLEAR}
  - helper function for masked merge
- Sub-module box_rd_port: one registered read port with bypass mux and range check, instantiated twice (A, B).
- Top holds the array, write logic, FSM, clear counter and err OR-reduction.

Test Plan:
1. Reset, then read A addr 0..3 -> rd_valid_a = 1 one cycle after each rd_en_a, rd_data_a = 0x00.
2. Write addr 2 = 0xA5 with mask 0xFF, then write addr 2 = 0x3C with mask 0x0F, then read both ports at addr 2 -> rd_data_a = rd_data_b = 0xAC next cycle.
3. Same-cycle write addr 1 = 0x77 (mask 0xFF) and read A addr 1 -> rd_data_a = 0x77 next cycle (bypass); read B addr 0 in the same cycle -> 0x00.
4. Fill addr 0..3 with 0x11/0x22/0x33/0x44, pulse clr_req -> busy high exactly 4 cycles, clr_done one pulse. Read during busy -> rd_valid = 0, err = 1. Afterwards all entries read 0x00.
5. DEPTH = 5 build: write addr 6 = 0xFF -> err pulse, no entry changes. Read addr 7 -> rd_valid = 1, data 0x00, err pulse.
6. Assert rst in the 2nd cycle of a clear -> busy = 0, clr_done never pulses, all entries 0, normal write/read works on the next cycle.
